dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
// - Memory-side responder for the MEM-stage data-memory interface: serves word loads and byte-masked stores.
// - Fixed LATENCY cycles per access. Holds the pipeline through busy (feeds pipeline_stall) until the access completes.
// - Sits between the MEM stage and the on-chip word-organised data RAM, which the block owns.
// PARAMETERS
// - DEPTH_LOG2  10  RAM holds 2**DEPTH_LOG2 32-bit words; addr bits above this are ignored (wrap).
// - LATENCY     3   cycles from acceptance to response, legal 1..15.
// PORTS
// - clk        in   1   clock, all state on rising edge
// - rst        in   1   reset, synchronous, active-high
// - req_valid  in   1   MEM stage presents an access; held stable while busy=1
// - req_we     in   1   1=store, 0=load
// - req_addr   in   30  word address (byte addr [31:2])
// - req_be     in   4   store byte enables, be[i] -> wdata[8i+7:8i]
// - req_wdata  in   32  store data
// - req_kill   in   1   MEM_FLUSH: abandon the in-flight access
// - busy       out  1   stall request to the pipeline (combinational)
// - resp_valid out  1   one-cycle pulse: access complete
// - rdata      out  32  load data, valid with resp_valid, held afterwards
// BEHAVIOUR
// - Reset: rst is synchronous and active-high. It forces state=IDLE, cnt=0, resp_valid=0, rdata=0.
// - Reset does not clear RAM contents. rst during WAIT aborts the access and never writes RAM.
// - FSM:
//   - IDLE: req_valid=1 captures we/addr/be/wdata.
//     - LATENCY=1: go to RESP.
//     - Otherwise: go to WAIT with cnt=LATENCY-2.
//   - WAIT: cnt==0 -> RESP, else cnt-1. Request ports are ignored; the captured copy is used.
//   - RESP:
//     - Store: RAM[addr] lanes with be=1 take wdata; be=0000 is a legal no-op.
//     - Load: rdata <= RAM[addr].
//     - resp_valid=1 for this one cycle, then go to IDLE.
// - rdata is registered on the RESP edge. It is visible the cycle after RESP, and resp_valid is aligned with it.
// - busy = req_valid & ~resp_valid & ~req_kill.
//   - A load or store issued at cycle 0 stalls cycles 0..LATENCY-1.
//   - It completes with resp_valid=1 and busy=0 at cycle LATENCY.
// - Back-to-back: if req_valid is still 1 in the resp_valid cycle, it is the next instruction's access.
//   - That access is accepted the following cycle (one IDLE cycle between accesses).
// - req_kill:
//   - In WAIT: go to IDLE with no RAM write and no resp_valid.
//   - In IDLE: the request is not accepted.
//   - In RESP: too late; the access completes normally.
// - Addressing: RAM index = req_addr[DEPTH_LOG2-1:0]. Address 2**DEPTH_LOG2 aliases word 0.
// - Simultaneous rst and req_valid: rst wins and the request is dropped.
// CONFIGURATION
// - DMEM_POSTED_WRITE_EN defined:
//   - A store in IDLE is written at that clock edge; busy=0 for it (zero stall).
//   - resp_valid pulses the next cycle; the FSM stays IDLE. Loads are unchanged.
//   - A load immediately after a posted store to the same word returns the new data.
// - Undefined: stores take the full LATENCY path, exactly like loads.
// TESTING
// - LATENCY=3. Store addr=0x10, be=1111, wdata=0xDEADBEEF at cycle 0.
//   - Expect busy=1 in cycles 0..2, resp_valid=1 at cycle 3.
//   - A load of 0x10 then returns rdata=0xDEADBEEF.
// - Byte mask: word 0x10=0xDEADBEEF, store be=0101, wdata=0x11223344.
//   - Expect a later load=0xDE22BE44. A be=0000 store leaves the word unchanged.
// - Kill: load issued, req_kill=1 at cycle 1.
//   - Expect no resp_valid, busy=0 from cycle 1, rdata unchanged.
//   - A store killed the same way leaves RAM unchanged.
// - Reset mid-WAIT: store in flight, rst=1 at cycle 1.
//   - Expect resp_valid=0, rdata=0, RAM word unchanged.
//   - The next request completes with the normal LATENCY.
// - Wrap, with DEPTH_LOG2=10: store 0xA5A5A5A5 to addr 0x400, load addr 0x000.
//   - Expect 0xA5A5A5A5.
// - DMEM_POSTED_WRITE_EN: store with busy=0 in its cycle, resp_valid next cycle, then load same addr.
//   - Expect new data after LATENCY, with LATENCY=1 and LATENCY=15 both checked.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : Fixed-latency data-memory responder for the MEM stage.       |
// |               Owns a word-organised RAM and serves word loads and stores   |
// |               with byte masks. Optional macro DMEM_POSTED_WRITE_EN makes   |
// |               stores zero-stall posted writes.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [29:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic        req_kill,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_init = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    w_do_access;

    logic                    r_cap_we;
    logic [DEPTH_LOG2-1:0]   r_cap_addr;
    logic [3:0]              r_cap_be;
    logic [31:0]             r_cap_wdata;

    logic                    w_accept;
    logic                    w_posted;
    logic                    w_op_we;
    logic [DEPTH_LOG2-1:0]   w_op_idx;
    logic [3:0]              w_op_be;
    logic [31:0]             w_op_wdata;

    logic [31:0]             r_mem [2**DEPTH_LOG2];

    generate
        if (DEPTH_LOG2 < 30) begin : g_addr_wrap
            logic w_unused_addr;
            assign w_unused_addr = ^req_addr[29:DEPTH_LOG2];
        end
    endgenerate

    // A request is never taken while a response is showing: that cycle's
    // request belongs to the next instruction and is picked up a cycle later.
    assign w_accept = (r_state == IDLE) & req_valid & ~req_kill & ~resp_valid;

`ifdef DMEM_POSTED_WRITE_EN
    assign w_posted = w_accept & req_we;
`else
    assign w_posted = 1'b0;
`endif

    assign busy = req_valid & ~resp_valid & ~req_kill & ~w_posted;

    // In IDLE the access (LATENCY=1 or posted) is performed straight from the ports.
    assign w_op_we    = (r_state == IDLE) ? req_we                       : r_cap_we;
    assign w_op_idx   = (r_state == IDLE) ? req_addr[DEPTH_LOG2-1:0]     : r_cap_addr;
    assign w_op_be    = (r_state == IDLE) ? req_be                       : r_cap_be;
    assign w_op_wdata = (r_state == IDLE) ? req_wdata                    : r_cap_wdata;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_do_access  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_posted) begin
                        w_do_access = 1'b1;
                    end else if (LATENCY == 1) begin
                        w_state_next = RESP;
                        w_do_access  = 1'b1;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = c_cnt_init;
                    end
                end
            end
            WAIT: begin
                if (req_kill) begin
                    w_state_next = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = RESP;
                    w_do_access  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            resp_valid <= 1'b0;
            rdata      <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            resp_valid <= w_do_access;
            if (w_do_access && !w_op_we) begin
                rdata <= r_mem[w_op_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_cap_we    <= req_we;
            r_cap_addr  <= req_addr[DEPTH_LOG2-1:0];
            r_cap_be    <= req_be;
            r_cap_wdata <= req_wdata;
        end
    end

    // RAM contents survive reset; only the write itself is suppressed by rst.
    always_ff @(posedge clk) begin
        if (!rst && w_do_access && w_op_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_be[i]) begin
                    r_mem[w_op_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
